// File: rtl/quad_cmd_pkg.sv
// Shared types and constants for the remote-command sequencer.
package quad_cmd_pkg;

    // Remote command opcodes understood by the sequencer.
    typedef enum logic [7:0] {
        CMD_SET_PTCH  = 8'h02,
        CMD_SET_ROLL  = 8'h03,
        CMD_SET_YAW   = 8'h04,
        CMD_SET_THRST = 8'h05,
        CMD_CALIBRATE = 8'h06,
        CMD_EMER_LAND = 8'h07,
        CMD_MTRS_OFF  = 8'h08
    } cmd_t;

    // Response bytes returned to the UART wrapper.
    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_SPINUP,
        S_CAL,
        S_ACK,
        S_TXWAIT
    } seq_state_t;

    // One buffered command as stored in the FIFO.
    typedef struct packed {
        logic [7:0]  cmd;
        logic [15:0] data;
    } cmd_entry_t;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO for buffered commands. Pointers carry an extra
// wrap bit so full and empty are distinguished without a separate counter.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_do_push;
    logic         w_do_pop;

    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    // Advance read/write pointers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every register samples pre-edge values.
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Write the storage array on push.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone define which entries are valid.
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cmd_sequencer.sv
// Remote command sequencer: buffers commands, executes them in order,
// owns the flight setpoints, sequences calibration and returns one
// response byte per command. A link watchdog forces a landing when the
// command link goes quiet with the motors running.
module cmd_sequencer
    import quad_cmd_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SPIN_W = 9,
    parameter int TMO_W  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_rdy,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    output logic        clr_cmd_rdy,
    output logic [7:0]  resp,
    output logic        send_resp,
    input  logic        resp_sent,
    output logic [15:0] d_ptch,
    output logic [15:0] d_roll,
    output logic [15:0] d_yaw,
    output logic [8:0]  thrst,
    output logic        inertial_cal,
    output logic        strt_cal,
    input  logic        cal_done,
    output logic        motors_off,
    output logic        fifo_full
);
    localparam logic [SPIN_W-1:0] SPIN_MAX = {SPIN_W{1'b1}};
    localparam logic [TMO_W-1:0]  WDOG_TOP = {TMO_W{1'b1}};

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    cmd_entry_t        r_hold;
    cmd_entry_t        w_fifo_dout;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_push;
    logic              w_pop;

    logic [SPIN_W-1:0] r_spin_cnt;
    logic [TMO_W-1:0]  r_wdog;
    logic              w_wdog_fire;

    logic [15:0]       r_ptch;
    logic [15:0]       r_roll;
    logic [15:0]       r_yaw;
    logic [8:0]        r_thrst;
    logic              r_motors_off;
    logic [7:0]        r_resp;

    logic              w_ld_ptch;
    logic              w_ld_roll;
    logic              w_ld_yaw;
    logic              w_ld_thrst;
    logic              w_land;
    logic              w_mtr_on;
    logic              w_mtr_off;
    logic              w_spin_clr;
    logic              w_resp_ld;
    logic [7:0]        w_resp_val;
    logic              w_send_resp;
    logic              w_strt_cal;

    // Accept a command whenever there is room; the wrapper holds it otherwise.
    assign w_push = cmd_rdy && !w_fifo_full && !rst;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(cmd_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({cmd, data}),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Forced landing: watchdog at its top value, motors running, link still silent.
    assign w_wdog_fire = (r_wdog == WDOG_TOP) && !r_motors_off && !cmd_rdy;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_ld_ptch    = 1'b0;
        w_ld_roll    = 1'b0;
        w_ld_yaw     = 1'b0;
        w_ld_thrst   = 1'b0;
        w_land       = 1'b0;
        w_mtr_on     = 1'b0;
        w_mtr_off    = 1'b0;
        w_spin_clr   = 1'b0;
        w_resp_ld    = 1'b0;
        w_resp_val   = ACK;
        w_send_resp  = 1'b0;
        w_strt_cal   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_resp_ld    = 1'b1;
                w_next_state = S_ACK;
                case (r_hold.cmd)
                    CMD_SET_PTCH:  w_ld_ptch  = 1'b1;
                    CMD_SET_ROLL:  w_ld_roll  = 1'b1;
                    CMD_SET_YAW:   w_ld_yaw   = 1'b1;
                    CMD_SET_THRST: w_ld_thrst = 1'b1;
                    CMD_EMER_LAND: w_land     = 1'b1;
                    CMD_MTRS_OFF:  w_mtr_off  = 1'b1;
                    CMD_CALIBRATE: begin
                        // The response for a calibration is deferred until cal_done.
                        w_resp_ld    = 1'b0;
                        w_mtr_on     = 1'b1;
                        w_spin_clr   = 1'b1;
                        w_next_state = S_SPINUP;
                    end
                    default:       w_resp_val = NAK;
                endcase
            end
            S_SPINUP: begin
                if (r_spin_cnt == SPIN_MAX) begin
                    w_strt_cal   = 1'b1;
                    w_next_state = S_CAL;
                end
            end
            S_CAL: begin
                if (cal_done) begin
                    w_resp_ld    = 1'b1;
                    w_next_state = S_ACK;
                end
            end
            S_ACK: begin
                w_send_resp  = 1'b1;
                w_next_state = S_TXWAIT;
            end
            S_TXWAIT: begin
                if (resp_sent) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Capture the FIFO head as the command under execution.
    always_ff @(posedge clk) begin
        if (w_pop) r_hold <= w_fifo_dout;
    end

    // Motor spin-up timer; runs only while in SPINUP.
    always_ff @(posedge clk) begin
        if (rst || w_spin_clr)       r_spin_cnt <= '0;
        else if (r_state == S_SPINUP) r_spin_cnt <= r_spin_cnt + 1'b1;
    end

    // Link watchdog: cleared by cmd_rdy, re-armed after a forced land, saturates otherwise.
    always_ff @(posedge clk) begin
        if (rst || cmd_rdy || w_wdog_fire) r_wdog <= '0;
        else if (r_wdog != WDOG_TOP)       r_wdog <= r_wdog + 1'b1;
    end

    // Setpoint registers; a forced or commanded landing overrides any load in the same clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptch  <= '0;
            r_roll  <= '0;
            r_yaw   <= '0;
            r_thrst <= '0;
        end else begin
            if (w_ld_ptch)  r_ptch  <= r_hold.data;
            if (w_ld_roll)  r_roll  <= r_hold.data;
            if (w_ld_yaw)   r_yaw   <= r_hold.data;
            if (w_ld_thrst) r_thrst <= r_hold.data[8:0];
            if (w_land || w_wdog_fire) begin
                r_ptch  <= '0;
                r_roll  <= '0;
                r_yaw   <= '0;
                r_thrst <= '0;
            end
        end
    end

    // Motor enable: calibration turns motors on, MTRS_OFF turns them off.
    always_ff @(posedge clk) begin
        if (rst)            r_motors_off <= 1'b1;
        else if (w_mtr_on)  r_motors_off <= 1'b0;
        else if (w_mtr_off) r_motors_off <= 1'b1;
    end

    // Response byte, held stable through the transmit.
    always_ff @(posedge clk) begin
        if (rst)            r_resp <= '0;
        else if (w_resp_ld) r_resp <= w_resp_val;
    end

    assign clr_cmd_rdy  = w_push;
    assign fifo_full    = w_fifo_full;
    assign send_resp    = w_send_resp && !rst;
    assign strt_cal     = w_strt_cal && !rst;
    assign inertial_cal = (r_state == S_SPINUP) || (r_state == S_CAL);
    assign resp         = r_resp;
    assign d_ptch       = r_ptch;
    assign d_roll       = r_roll;
    assign d_yaw        = r_yaw;
    assign thrst        = r_thrst;
    assign motors_off   = r_motors_off;

endmodule
